// File: rtl/asr_disp_pkg.sv
// Shared types and helpers for the ASR result display path:
// word-code width, display FSM states and the one-hot check.
package asr_disp_pkg;

   localparam int CODE_W = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } disp_state_t;

   // True when exactly one bit of the code is set (zero is rejected).
   function automatic logic is_onehot(input logic [CODE_W-1:0] code);
      return (code != '0) && ((code & (code - CODE_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/asr_result_scheduler_if.sv
// Result handshake from the ASR network into the display scheduler.
interface asr_result_scheduler_if
   import asr_disp_pkg::*;
();

   // valid/ready: a transfer happens on a rising clk edge where result_valid
   // and result_ready are both high. result_code must be stable while
   // result_valid is high; result_ready may drop without warning (full/flush).
   logic              result_valid;
   logic [CODE_W-1:0] result_code;
   logic              result_ready;

   modport master (output result_valid, output result_code, input result_ready);
   modport slave  (input result_valid, input result_code, output result_ready);

endinterface

// File: rtl/asr_result_fifo.sv
// Synchronous FIFO for accepted word codes; head is read from registered
// storage, so a word written this edge is visible to pop on the next one.
module asr_result_fifo
   import asr_disp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [CODE_W-1:0]          din,
   output logic [CODE_W-1:0]          dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [CODE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         // Pointers wrap naturally since DEPTH is a power of two.
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/asr_result_scheduler.sv
// Accepts one-hot word codes, buffers them, and shows each on the LED decode
// input for HOLD_CYCLES followed by a blank GAP_CYCLES.
module asr_result_scheduler
   import asr_disp_pkg::*;
#(
   parameter int HOLD_CYCLES = 32000,
   parameter int GAP_CYCLES  = 3200,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   asr_result_scheduler_if.slave         res,
   input  logic                          flush,
   output logic [CODE_W-1:0]             network_encode_output,
   output logic                          display_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    drop_count,
   output disp_state_t                   fsm_state
);

   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);

   disp_state_t       state, state_nxt;
   logic [CNT_W-1:0]  timer, timer_nxt;
   logic [CODE_W-1:0] disp, disp_nxt;
   logic              fifo_pop;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CODE_W-1:0] fifo_dout;
   logic              accept;
   logic              drop_inc;

   assign res.result_ready = !fifo_full && !flush;
   assign accept           = res.result_valid && res.result_ready;
   assign fifo_push        = accept && is_onehot(res.result_code);
   assign drop_inc         = accept && !is_onehot(res.result_code);

   assign network_encode_output = disp;
   assign display_busy          = (state != IDLE);
   assign fsm_state             = state;

   asr_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .clear (flush),
      .din   (res.result_code),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
         disp  <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         disp  <= disp_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      disp_nxt  = disp;
      fifo_pop  = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
         timer_nxt = '0;
         disp_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  disp_nxt  = fifo_dout;
                  timer_nxt = HOLD_RELOAD;
                  state_nxt = SHOW;
               end
            end
            SHOW: begin
               if (timer == '0) begin
                  disp_nxt  = '0;
                  timer_nxt = GAP_RELOAD;
                  state_nxt = GAP;
               end else begin
                  timer_nxt = timer - CNT_W'(1);
               end
            end
            GAP: begin
               // Chain straight into the next word so back-to-back words
               // keep a period of HOLD+GAP with no idle cycle.
               if (timer == '0) begin
                  if (!fifo_empty) begin
                     fifo_pop  = 1'b1;
                     disp_nxt  = fifo_dout;
                     timer_nxt = HOLD_RELOAD;
                     state_nxt = SHOW;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  timer_nxt = timer - CNT_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
               disp_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (drop_inc && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end

endmodule

// File: doc/asr_result_scheduler.md
# asr_result_scheduler

Sequences recognised-word codes from the ASR network output onto the one-hot code input of the 7-segment LED decode stage. Accepts results through a valid/ready handshake and discards any code that is not exactly one-hot, counting each discard. Buffers accepted results in a small FIFO. Presents each buffered word for a fixed hold time, then drives a blank gap so that repeated words remain visually distinct.

## Interface
Parameters:
- HOLD_CYCLES, 32000: cycles each word is driven to the decoder; legal range 1 to 2^CNT_W−1.
- GAP_CYCLES, 3200: blank cycles after each word; legal range 1 to 2^CNT_W−1.
- FIFO_DEPTH, 4: result buffer entries; must be a power of 2, at least 2.
- CNT_W, 16: width of the hold/gap timer.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- result_valid, input, 1: result_code is valid this cycle.
- result_code, input, 20: candidate word code, one-hot (bit i = word i+1).
- result_ready, output, 1: the block can accept a result. Equals !fifo_full && !flush.
- flush, input, 1: synchronous clear of the FIFO and the display.
- network_encode_output, output, 20: registered code to the LED decode stage; 0 means blank.
- display_busy, output, 1: high when the FSM is in SHOW or GAP.
- fifo_count, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.
- drop_count, output, 8: count of rejected codes, saturating at 255.

## Operation
- Handshake: a transfer occurs when result_valid && result_ready.
  - If result_code has exactly one bit set, the code is written to the FIFO.
  - Otherwise the code is not written and drop_count increments. This includes all-zero and multi-bit codes.
- While result_ready is low, result_valid is ignored: no write and no drop count.
- FSM states: IDLE, SHOW, GAP.
  - IDLE, FIFO not empty: pop the head into the display register; timer ← HOLD_CYCLES−1; go to SHOW.
  - SHOW, timer==0: display register ← 0; timer ← GAP_CYCLES−1; go to GAP. Otherwise the timer decrements.
  - GAP, timer==0: if the FIFO is not empty, pop directly into SHOW (timer reload as in IDLE); otherwise go to IDLE. Otherwise the timer decrements.
- network_encode_output equals the display register. It is nonzero only in SHOW.
- Same-cycle push and pop are legal; the count is unchanged.
  - There is no bypass: a word written into an empty FIFO is popped on the following edge at the earliest.
- flush has priority over every other event. On the next edge:
  - the FIFO is emptied;
  - the FSM goes to IDLE;
  - the display register and timer are cleared to 0;
  - drop_count is kept.
  - A result presented in the same cycle as flush is neither written nor dropped, because result_ready is low.
- drop_count holds at 255 once it reaches 255.

## Timing
- Reset values:
  - network_encode_output = 0;
  - display_busy = 0;
  - fifo_count = 0;
  - drop_count = 0;
  - result_ready = 1 (combinational from registered state);
  - FSM = IDLE;
  - timer = 0.
- Latency, input to output: a word accepted at edge E0 with the FSM in IDLE appears on network_encode_output after edge E1.
- Each word is nonzero for exactly HOLD_CYCLES cycles, followed by exactly GAP_CYCLES zero cycles.
- Back-to-back words have a period of HOLD_CYCLES+GAP_CYCLES cycles, with no extra IDLE cycle.
- FIFO full: result_ready is low. The FIFO pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-word: all registers return to their reset values immediately (asynchronously), and buffered words are lost.
- End-to-end delay to the segments: this block's latency plus the decode stage's 3 cycles.

## Structure
- Shared package asr_disp_pkg contains:
  - CODE_W = 20;
  - the FSM state enum (IDLE, SHOW, GAP);
  - function is_onehot(code) → 1 bit.
- One sub-module: asr_result_fifo.
  - Synchronous FIFO of width CODE_W and depth FIFO_DEPTH.
  - Ports: push, pop, clear, din, dout, count, full, empty.
  - Registered dout head; same-cycle push and pop supported.
- The FSM, timer, display register and drop counter are in the top module.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4.
1. Reset, then one transfer of code 0x00004 → output is 0x00004 on the cycle after the accept, for 4 cycles, then 0 for 2 cycles; FSM returns to IDLE and display_busy drops.
2. Three back-to-back transfers 0x00001, 0x00002, 0x80000 → outputs in that order with a period of 6 cycles, no idle gap between words, and fifo_count decrements on each pop.
3. Transfers of 0x00000, 0x00003, then 0x00010 → drop_count = 2, and only 0x00010 is displayed.
4. Five words with the FSM stalled in SHOW → result_ready goes low when fifo_count = 4, and the fifth word is held until ready; no drops occur.
5. flush mid-SHOW with 3 words buffered, result_valid high in the same cycle → next cycle: output 0, fifo_count 0, FSM IDLE, drop_count unchanged, and the presented word is not written.
6. 300 invalid codes → drop_count saturates at 255. Then assert rst_n low during SHOW → all outputs return to their reset values without waiting for a clock edge.
